// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce stage.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int GLITCH_COUNT_W          = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and stability counter.
// The glitch flag exists only when DEBOUNCE_GLITCH_COUNT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       pressed_async,
  output logic       clean,
  output logic       changed,
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  output logic       glitch,
`endif
  output logic [1:0] debug_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  assign debug_state = state;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= pressed_async;
      sync_s    <= sync_meta;
    end
  end

  // An abort drops back to the stable state with cnt=0, so the next arm starts from scratch.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state   <= RELEASED;
      cnt     <= '0;
      clean   <= 1'b0;
      changed <= 1'b0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      glitch  <= 1'b0;
`endif
    end else begin
      changed <= 1'b0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      glitch  <= 1'b0;
`endif
      case (state)
        RELEASED: begin
          if (sync_s) begin
            state <= ARM_PRESS;
            cnt   <= CNT_W'(1);
          end
        end
        ARM_PRESS: begin
          if (!sync_s) begin
            state  <= RELEASED;
            cnt    <= '0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
            glitch <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            clean   <= 1'b1;
            changed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_s) begin
            state <= ARM_RELEASE;
            cnt   <= CNT_W'(1);
          end
        end
        ARM_RELEASE: begin
          if (sync_s) begin
            state  <= PRESSED;
            cnt    <= '0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
            glitch <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= RELEASED;
            cnt     <= '0;
            clean   <= 1'b0;
            changed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioning: normalise polarity, then debounce each channel independently.
// Optional saturating glitch counter enabled by DEBOUNCE_GLITCH_COUNT_EN.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                      vga_clock,
  input  logic                      reset,
  input  logic [N_BUTTONS-1:0]      raw_buttons,
  output logic [N_BUTTONS-1:0]      clean,
  output logic [N_BUTTONS-1:0]      changed,
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  output logic [GLITCH_COUNT_W-1:0] glitch_count,
`endif
  output logic [2*N_BUTTONS-1:0]    debug_state
);

  logic [N_BUTTONS-1:0] pressed_async;

  assign pressed_async = (ACTIVE_LOW != 0) ? ~raw_buttons : raw_buttons;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [N_BUTTONS-1:0] glitch_vec;
`endif

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .vga_clock    (vga_clock),
      .reset        (reset),
      .pressed_async(pressed_async[i]),
      .clean        (clean[i]),
      .changed      (changed[i]),
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      .glitch       (glitch_vec[i]),
`endif
      .debug_state  (debug_state[2*i +: 2])
    );
  end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  // Counts cycles with any abort, not aborts per channel.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      glitch_count <= '0;
    end else if ((|glitch_vec) && (glitch_count != '1)) begin
      glitch_count <= glitch_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with N_BUTTONS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Builds with or without DEBOUNCE_GLITCH_COUNT_EN.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int W  = 2 + 2 + 32;

  logic          vga_clock;
  logic          reset;
  logic [NB-1:0] raw_buttons;
  logic [NB-1:0] clean;
  logic [NB-1:0] changed;
  logic [2*NB-1:0] debug_state;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [GLITCH_COUNT_W-1:0] glitch_count;
`endif

  button_debouncer #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1)
  ) dut (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .raw_buttons (raw_buttons),
    .clean       (clean),
    .changed     (changed),
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    .glitch_count(glitch_count),
`endif
    .debug_state (debug_state)
  );

  // Clock / reset
  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  logic [31:0] cyc = 32'd0;
  always @(posedge vga_clock) cyc <= cyc + 32'd1;

  // Scoreboard: {clean, changed, posedge count at which the pulse is visible}
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A new raw level driven now reaches clean after DC+2 posedges.
  task automatic expect_change(input logic [1:0] cl, input logic [1:0] ch);
    exp_q.push_back({cl, ch, cyc + 32'(DC + 2)});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge vga_clock);
  endtask

  // Monitor: every changed pulse must match the next expectation exactly.
  always @(negedge vga_clock) begin
    if (reset && changed != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_changed: clean=%b changed=%b cyc=%0d with no expectation",
                 clean, changed, cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({clean, changed, cyc} !== e) begin
          failures++;
          $display("FAIL changed_event: got clean=%b changed=%b cyc=%0d expected clean=%b changed=%b cyc=%0d",
                   clean, changed, cyc, e[35:34], e[33:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    raw_buttons = 2'b11;
    wait_cycles(3);
    check("reset_clean", 32'(clean), 32'd0);
    check("reset_changed", 32'(changed), 32'd0);
    check("reset_state", 32'(debug_state), 32'd0);
    reset = 1'b1;

    // Idle released
    wait_cycles(20);
    check("idle_clean", 32'(clean), 32'd0);
    check("idle_changed", 32'(changed), 32'd0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("idle_glitch", 32'(glitch_count), 32'd0);
`endif

    // Steady press on channel 0
    raw_buttons = 2'b10;
    expect_change(2'b01, 2'b01);
    wait_cycles(5);
    check("press0_early", 32'(clean), 32'd0);
    wait_cycles(5);
    check("press0_clean", 32'(clean), 32'd1);
    check("press0_pulse_gone", 32'(changed), 32'd0);

    // Steady release
    raw_buttons = 2'b11;
    expect_change(2'b00, 2'b01);
    wait_cycles(10);
    check("release0_clean", 32'(clean), 32'd0);

    // Two 3-sample bounces on channel 0
    for (int k = 0; k < 2; k++) begin
      raw_buttons = 2'b10;
      wait_cycles(3);
      raw_buttons = 2'b11;
      wait_cycles(6);
    end
    check("bounce_clean", 32'(clean), 32'd0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("bounce_glitch", 32'(glitch_count), 32'd2);
`endif

    // Simultaneous bounce on both channels counts once
    raw_buttons = 2'b00;
    wait_cycles(2);
    raw_buttons = 2'b11;
    wait_cycles(6);
    check("dual_bounce_clean", 32'(clean), 32'd0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("dual_bounce_glitch", 32'(glitch_count), 32'd3);
`endif

    // Channel 1 pressed steadily while channel 0 bounces three times
    raw_buttons = 2'b00;
    expect_change(2'b10, 2'b10);
    for (int k = 0; k < 3; k++) begin
      raw_buttons[0] = 1'b0;
      wait_cycles(2);
      raw_buttons[0] = 1'b1;
      wait_cycles(2);
    end
    wait_cycles(6);
    check("indep_clean", 32'(clean), 32'h2);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("indep_glitch", 32'(glitch_count), 32'd6);
`endif
    raw_buttons = 2'b11;
    expect_change(2'b00, 2'b10);
    wait_cycles(10);
    check("release1_clean", 32'(clean), 32'd0);

    // Reset during ARM_RELEASE, button held through reset
    raw_buttons = 2'b10;
    expect_change(2'b01, 2'b01);
    wait_cycles(10);
    check("pre_reset_clean", 32'(clean), 32'd1);
    raw_buttons = 2'b11;
    wait_cycles(4);
    check("arm_release_state", 32'(debug_state[1:0]), 32'(ARM_RELEASE));
    reset       = 1'b0;
    raw_buttons = 2'b10;
    #1;
    check("midarm_reset_clean", 32'(clean), 32'd0);
    check("midarm_reset_changed", 32'(changed), 32'd0);
    check("midarm_reset_state", 32'(debug_state), 32'd0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("midarm_reset_glitch", 32'(glitch_count), 32'd0);
`endif
    wait_cycles(3);
    reset = 1'b1;
    expect_change(2'b01, 2'b01);
    wait_cycles(10);
    check("held_after_reset_clean", 32'(clean), 32'd1);

    wait_cycles(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
